// File: rtl/rx_message_buffer_pkg.sv
// Shared types and constants for the RX message buffer slice.
package vsi_rx_pkg;

  localparam int ADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_DISCARD = 2'd2
  } rx_state_e;

  localparam logic BANK_FREE = 1'b0;
  localparam logic BANK_FULL = 1'b1;

  // Event counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rx_message_buffer_dpram.sv
// Simple dual-port byte RAM: one write port, one registered read port.
module rx_dpram #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [0:(2**AW)-1];
  logic [7:0] rdata_q;

  // Storage array write port; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port, cleared on reset so the host sees zero data.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rdata_q <= 8'h00;
    end else begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/rx_message_buffer.sv
// Ping-pong message buffer behind the protocol receiver: terminates the RX
// write handshake, commits a bank only on a correct end-of-message and
// presents committed messages to the host in arrival order.
// rst_l is expected to be released synchronously to clk by the reset tree.
module rx_message_buffer
  import vsi_rx_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic [7:0]        rx_flag,
  input  logic [15:0]       rx_byte_number,
  input  logic              rx_flag_byte_number_rd_en,
  input  logic              rx_ram_req_wr,
  output logic              rx_ram_rdy_wr,
  input  logic [15:0]       rx_ram_addr,
  input  logic [7:0]        rx_ram_data,
  input  logic              rx_end_message,
  input  logic              rx_message_right,
  input  logic              rx_end_message_line,
  output logic              msg_valid,
  output logic [7:0]        msg_flag,
  output logic [15:0]       msg_len,
  output logic              msg_line,
  input  logic              msg_ack,
  input  logic [ADDR_W-1:0] host_rd_addr,
  output logic [7:0]        host_rd_data,
  output logic [7:0]        drop_cnt,
  output logic [7:0]        bad_cnt
);

  localparam logic [16:0] BANK_BYTES = 17'd1 << ADDR_W;

  rx_state_e        state_q, state_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic             ovf_q, ovf_d;
  logic             req_seen_q, req_seen_d;
  logic             rdy_q, rdy_d;
  logic [1:0]       bank_st_q, bank_st_d;
  logic [1:0]       q_cnt_q, q_cnt_d;
  logic [1:0][7:0]  desc_flag_q, desc_flag_d;
  logic [1:0][15:0] desc_len_q, desc_len_d;
  logic [1:0]       desc_line_q, desc_line_d;
  logic             msg_valid_q, msg_valid_d;
  logic [7:0]       msg_flag_q, msg_flag_d;
  logic [15:0]      msg_len_q, msg_len_d;
  logic             msg_line_q, msg_line_d;
  logic [7:0]       drop_q, drop_d;
  logic [7:0]       bad_q, bad_d;

  logic             accept_s, addr_ok_s, ram_we_s, commit_s, ack_s, sel_s;

  // Next-state logic: handshake, message FSM, bank bookkeeping, descriptors.
  always_comb begin
    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    ovf_d       = ovf_q;
    bank_st_d   = bank_st_q;
    q_cnt_d     = q_cnt_q;
    desc_flag_d = desc_flag_q;
    desc_len_d  = desc_len_q;
    desc_line_d = desc_line_q;
    drop_d      = drop_q;
    bad_d       = bad_q;
    sel_s       = 1'b0;
    commit_s    = 1'b0;
    ram_we_s    = 1'b0;

    // A request is accepted once per assertion and acked on the next cycle in any state.
    accept_s   = rx_ram_req_wr && !req_seen_q;
    req_seen_d = rx_ram_req_wr;
    rdy_d      = accept_s;
    addr_ok_s  = ({1'b0, rx_ram_addr} < BANK_BYTES);
    ack_s      = msg_ack && (q_cnt_q != 2'd0);

    if (accept_s && (state_q == ST_RECV)) begin
      if (addr_ok_s) begin
        ram_we_s = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else begin
      ram_we_s = 1'b0;
    end

    if (rx_flag_byte_number_rd_en) begin
      // A new start always wins; an open reception is aborted.
      if (state_q == ST_RECV) begin
        bad_d = sat_inc8(bad_q);
      end else begin
        bad_d = bad_q;
      end
      if ((bank_st_q[0] == BANK_FREE) || (bank_st_q[1] == BANK_FREE)) begin
        sel_s              = (bank_st_q[0] == BANK_FREE) ? 1'b0 : 1'b1;
        state_d            = ST_RECV;
        wr_bank_d          = sel_s;
        ovf_d              = ({1'b0, rx_byte_number} > BANK_BYTES);
        desc_flag_d[sel_s] = rx_flag;
        desc_len_d[sel_s]  = rx_byte_number;
      end else begin
        state_d = ST_DISCARD;
        drop_d  = sat_inc8(drop_q);
      end
    end else if (rx_end_message) begin
      case (state_q)
        ST_RECV: begin
          if (rx_message_right && !ovf_q) begin
            commit_s = 1'b1;
          end else begin
            bad_d = sat_inc8(bad_q);
          end
          state_d = ST_IDLE;
        end
        ST_DISCARD: state_d = ST_IDLE;
        ST_IDLE:    state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end

    // Ack frees the presented bank; commit fills the (always free) write bank.
    if (ack_s) begin
      bank_st_d[rd_bank_q] = BANK_FREE;
      rd_bank_d            = ~rd_bank_q;
    end else if (commit_s && (q_cnt_q == 2'd0)) begin
      rd_bank_d = wr_bank_q;
    end else begin
      rd_bank_d = rd_bank_q;
    end
    if (commit_s) begin
      bank_st_d[wr_bank_q]   = BANK_FULL;
      desc_line_d[wr_bank_q] = rx_end_message_line;
    end else begin
      bank_st_d[wr_bank_q]   = bank_st_d[wr_bank_q];
    end
    case ({commit_s, ack_s})
      2'b10:   q_cnt_d = q_cnt_q + 2'd1;
      2'b01:   q_cnt_d = q_cnt_q - 2'd1;
      default: q_cnt_d = q_cnt_q;
    endcase

    // Presented descriptor follows the head of the order queue.
    msg_valid_d = (q_cnt_d != 2'd0);
    if (msg_valid_d) begin
      msg_flag_d = desc_flag_d[rd_bank_d];
      msg_len_d  = desc_len_d[rd_bank_d];
      msg_line_d = desc_line_d[rd_bank_d];
    end else begin
      msg_flag_d = 8'h00;
      msg_len_d  = 16'h0000;
      msg_line_d = 1'b0;
    end
  end

  // State register for the FSM, handshake and all registered outputs.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= ST_IDLE;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      ovf_q       <= 1'b0;
      req_seen_q  <= 1'b0;
      rdy_q       <= 1'b0;
      bank_st_q   <= {BANK_FREE, BANK_FREE};
      q_cnt_q     <= 2'd0;
      desc_flag_q <= '0;
      desc_len_q  <= '0;
      desc_line_q <= 2'b00;
      msg_valid_q <= 1'b0;
      msg_flag_q  <= 8'h00;
      msg_len_q   <= 16'h0000;
      msg_line_q  <= 1'b0;
      drop_q      <= 8'h00;
      bad_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      ovf_q       <= ovf_d;
      req_seen_q  <= req_seen_d;
      rdy_q       <= rdy_d;
      bank_st_q   <= bank_st_d;
      q_cnt_q     <= q_cnt_d;
      desc_flag_q <= desc_flag_d;
      desc_len_q  <= desc_len_d;
      desc_line_q <= desc_line_d;
      msg_valid_q <= msg_valid_d;
      msg_flag_q  <= msg_flag_d;
      msg_len_q   <= msg_len_d;
      msg_line_q  <= msg_line_d;
      drop_q      <= drop_d;
      bad_q       <= bad_d;
    end
  end

  rx_dpram #(.AW(ADDR_W + 1)) u_ram (
    .clk   (clk),
    .rst_l (rst_l),
    .we    (ram_we_s),
    .waddr ({wr_bank_q, rx_ram_addr[ADDR_W-1:0]}),
    .wdata (rx_ram_data),
    .raddr ({rd_bank_q, host_rd_addr}),
    .rdata (host_rd_data)
  );

  assign rx_ram_rdy_wr = rdy_q;
  assign msg_valid     = msg_valid_q;
  assign msg_flag      = msg_flag_q;
  assign msg_len       = msg_len_q;
  assign msg_line      = msg_line_q;
  assign drop_cnt      = drop_q;
  assign bad_cnt       = bad_q;

endmodule

// File: tb/tb_rx_message_buffer.sv
// Directed self-checking bench for rx_message_buffer (ADDR_W = 10).
module tb_rx_message_buffer;

  logic        clk;
  logic        rst_l;
  logic [7:0]  rx_flag;
  logic [15:0] rx_byte_number;
  logic        rx_flag_byte_number_rd_en;
  logic        rx_ram_req_wr;
  logic        rx_ram_rdy_wr;
  logic [15:0] rx_ram_addr;
  logic [7:0]  rx_ram_data;
  logic        rx_end_message;
  logic        rx_message_right;
  logic        rx_end_message_line;
  logic        msg_valid;
  logic [7:0]  msg_flag;
  logic [15:0] msg_len;
  logic        msg_line;
  logic        msg_ack;
  logic [9:0]  host_rd_addr;
  logic [7:0]  host_rd_data;
  logic [7:0]  drop_cnt;
  logic [7:0]  bad_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  rx_message_buffer #(.ADDR_W(10)) dut (
    .clk                       (clk),
    .rst_l                     (rst_l),
    .rx_flag                   (rx_flag),
    .rx_byte_number            (rx_byte_number),
    .rx_flag_byte_number_rd_en (rx_flag_byte_number_rd_en),
    .rx_ram_req_wr             (rx_ram_req_wr),
    .rx_ram_rdy_wr             (rx_ram_rdy_wr),
    .rx_ram_addr               (rx_ram_addr),
    .rx_ram_data               (rx_ram_data),
    .rx_end_message            (rx_end_message),
    .rx_message_right          (rx_message_right),
    .rx_end_message_line       (rx_end_message_line),
    .msg_valid                 (msg_valid),
    .msg_flag                  (msg_flag),
    .msg_len                   (msg_len),
    .msg_line                  (msg_line),
    .msg_ack                   (msg_ack),
    .host_rd_addr              (host_rd_addr),
    .host_rd_data              (host_rd_data),
    .drop_cnt                  (drop_cnt),
    .bad_cnt                   (bad_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_msg(input logic [7:0] flag, input logic [15:0] len);
    rx_flag = flag;
    rx_byte_number = len;
    rx_flag_byte_number_rd_en = 1'b1;
    step();
    rx_flag_byte_number_rd_en = 1'b0;
  endtask

  // One write: rdy must pulse exactly one cycle after req rises.
  task automatic wr_byte(input string tag, input logic [15:0] addr, input logic [7:0] data);
    rx_ram_addr = addr;
    rx_ram_data = data;
    rx_ram_req_wr = 1'b1;
    step();
    chk({tag, "_rdy_hi"}, {31'd0, rx_ram_rdy_wr}, 32'd1);
    rx_ram_req_wr = 1'b0;
    step();
    chk({tag, "_rdy_lo"}, {31'd0, rx_ram_rdy_wr}, 32'd0);
  endtask

  task automatic end_msg(input logic right, input logic line);
    rx_message_right = right;
    rx_end_message_line = line;
    rx_end_message = 1'b1;
    step();
    rx_end_message = 1'b0;
  endtask

  task automatic ack();
    msg_ack = 1'b1;
    step();
    msg_ack = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [9:0] addr, input logic [7:0] exp);
    host_rd_addr = addr;
    step();
    chk(tag, {24'd0, host_rd_data}, {24'd0, exp});
  endtask

  initial begin
    rst_l = 1'b0;
    rx_flag = 8'h00;
    rx_byte_number = 16'h0000;
    rx_flag_byte_number_rd_en = 1'b0;
    rx_ram_req_wr = 1'b0;
    rx_ram_addr = 16'h0000;
    rx_ram_data = 8'h00;
    rx_end_message = 1'b0;
    rx_message_right = 1'b0;
    rx_end_message_line = 1'b0;
    msg_ack = 1'b0;
    host_rd_addr = 10'd0;

    // Reset state
    step();
    step();
    chk("rst_valid", {31'd0, msg_valid}, 32'd0);
    chk("rst_rdy", {31'd0, rx_ram_rdy_wr}, 32'd0);
    chk("rst_flag", {24'd0, msg_flag}, 32'd0);
    chk("rst_len", {16'd0, msg_len}, 32'd0);
    chk("rst_rdata", {24'd0, host_rd_data}, 32'd0);
    chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
    chk("rst_bad", {24'd0, bad_cnt}, 32'd0);
    rst_l = 1'b1;
    step();

    // 1: good message
    start_msg(8'h11, 16'd4);
    wr_byte("t1_w0", 16'd0, 8'hA0);
    wr_byte("t1_w1", 16'd1, 8'hA1);
    wr_byte("t1_w2", 16'd2, 8'hA2);
    wr_byte("t1_w3", 16'd3, 8'hA3);
    chk("t1_valid_pre", {31'd0, msg_valid}, 32'd0);
    end_msg(1'b1, 1'b1);
    chk("t1_valid", {31'd0, msg_valid}, 32'd1);
    chk("t1_flag", {24'd0, msg_flag}, 32'h11);
    chk("t1_len", {16'd0, msg_len}, 32'd4);
    chk("t1_line", {31'd0, msg_line}, 32'd1);
    rd_chk("t1_rd2", 10'd2, 8'hA2);
    rd_chk("t1_rd0", 10'd0, 8'hA0);
    ack();
    chk("t1_ack_valid", {31'd0, msg_valid}, 32'd0);

    // 2: wrong message discarded
    start_msg(8'h11, 16'd4);
    wr_byte("t2_w0", 16'd0, 8'hB0);
    end_msg(1'b0, 1'b0);
    chk("t2_valid", {31'd0, msg_valid}, 32'd0);
    chk("t2_bad", {24'd0, bad_cnt}, 32'd1);

    // 3: two queued, third dropped, ack advances
    start_msg(8'h21, 16'd2);
    wr_byte("t3_a0", 16'd0, 8'hC0);
    wr_byte("t3_a1", 16'd1, 8'hC1);
    end_msg(1'b1, 1'b0);
    chk("t3_a_valid", {31'd0, msg_valid}, 32'd1);
    chk("t3_a_flag", {24'd0, msg_flag}, 32'h21);
    start_msg(8'h22, 16'd3);
    wr_byte("t3_b0", 16'd0, 8'hD0);
    end_msg(1'b1, 1'b1);
    chk("t3_b_flag_still_a", {24'd0, msg_flag}, 32'h21);
    start_msg(8'h23, 16'd1);
    chk("t3_drop", {24'd0, drop_cnt}, 32'd1);
    wr_byte("t3_c0", 16'd0, 8'hEE);
    end_msg(1'b1, 1'b0);
    chk("t3_flag_a", {24'd0, msg_flag}, 32'h21);
    chk("t3_len_a", {16'd0, msg_len}, 32'd2);
    chk("t3_bad_same", {24'd0, bad_cnt}, 32'd1);
    rd_chk("t3_rd_a1", 10'd1, 8'hC1);
    ack();
    chk("t3_b_valid", {31'd0, msg_valid}, 32'd1);
    chk("t3_b_flag", {24'd0, msg_flag}, 32'h22);
    chk("t3_b_len", {16'd0, msg_len}, 32'd3);
    chk("t3_b_line", {31'd0, msg_line}, 32'd1);
    rd_chk("t3_rd_b0", 10'd0, 8'hD0);
    ack();
    chk("t3_empty", {31'd0, msg_valid}, 32'd0);
    ack();
    chk("t3_spurious_ack", {31'd0, msg_valid}, 32'd0);

    // 4: overflow by length, then by address
    start_msg(8'h30, 16'h0500);
    end_msg(1'b1, 1'b0);
    chk("t4_len_valid", {31'd0, msg_valid}, 32'd0);
    chk("t4_len_bad", {24'd0, bad_cnt}, 32'd2);
    start_msg(8'h31, 16'h0400);
    wr_byte("t4_w400", 16'h0400, 8'h99);
    end_msg(1'b1, 1'b0);
    chk("t4_addr_valid", {31'd0, msg_valid}, 32'd0);
    chk("t4_addr_bad", {24'd0, bad_cnt}, 32'd3);

    // 5: commit and ack in the same cycle
    start_msg(8'h41, 16'd1);
    wr_byte("t5_e0", 16'd0, 8'h41);
    end_msg(1'b1, 1'b1);
    chk("t5_e_flag", {24'd0, msg_flag}, 32'h41);
    start_msg(8'h42, 16'd2);
    wr_byte("t5_f0", 16'd0, 8'hF0);
    wr_byte("t5_f1", 16'd1, 8'hF1);
    msg_ack = 1'b1;
    end_msg(1'b1, 1'b0);
    msg_ack = 1'b0;
    chk("t5_valid", {31'd0, msg_valid}, 32'd1);
    chk("t5_flag", {24'd0, msg_flag}, 32'h42);
    chk("t5_len", {16'd0, msg_len}, 32'd2);
    chk("t5_line", {31'd0, msg_line}, 32'd0);
    rd_chk("t5_rd1", 10'd1, 8'hF1);
    ack();
    chk("t5_empty", {31'd0, msg_valid}, 32'd0);

    // 6: reset mid-message with req held
    start_msg(8'h50, 16'd1);
    wr_byte("t6_g0", 16'd0, 8'h50);
    end_msg(1'b1, 1'b0);
    chk("t6_pre_valid", {31'd0, msg_valid}, 32'd1);
    start_msg(8'h51, 16'd4);
    rx_ram_addr = 16'd0;
    rx_ram_data = 8'h77;
    rx_ram_req_wr = 1'b1;
    step();
    chk("t6_rdy_pre", {31'd0, rx_ram_rdy_wr}, 32'd1);
    #1;
    rst_l = 1'b0;
    #1;
    chk("t6_rdy_rst", {31'd0, rx_ram_rdy_wr}, 32'd0);
    chk("t6_valid_rst", {31'd0, msg_valid}, 32'd0);
    chk("t6_drop_rst", {24'd0, drop_cnt}, 32'd0);
    chk("t6_bad_rst", {24'd0, bad_cnt}, 32'd0);
    rx_ram_req_wr = 1'b0;
    step();
    rst_l = 1'b1;
    step();
    start_msg(8'h61, 16'd1);
    wr_byte("t6_h0", 16'd0, 8'hE5);
    end_msg(1'b1, 1'b1);
    chk("t6_h_valid", {31'd0, msg_valid}, 32'd1);
    chk("t6_h_flag", {24'd0, msg_flag}, 32'h61);
    chk("t6_h_line", {31'd0, msg_line}, 32'd1);
    rd_chk("t6_h_rd0", 10'd0, 8'hE5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
